// File: rtl/mbc_pkg.sv
// rtl/mbc_pkg.sv - shared MBC1 responder types, space codes and address map constants
package mbc_pkg;

    localparam int MEM_AW = 21;

    localparam logic [15:0] ROM_END   = 16'h7FFF;
    localparam logic [15:0] CRAM_BASE = 16'hA000;
    localparam logic [15:0] CRAM_END  = 16'hBFFF;
    localparam logic [15:0] WRAM_BASE = 16'hC000;
    localparam logic [15:0] ECHO_END  = 16'hFDFF;

    localparam logic [1:0] SPACE_ROM  = 2'd0;
    localparam logic [1:0] SPACE_CRAM = 2'd1;
    localparam logic [1:0] SPACE_WRAM = 2'd2;

    typedef enum logic [1:0] {
        REGION_ROM,
        REGION_CRAM,
        REGION_WRAM,
        REGION_UNMAPPED
    } region_t;

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } state_t;

endpackage

// File: rtl/mbc1_responder_if.sv
// rtl/mbc1_responder_if.sv - backing-store request/acknowledge bus
interface mbc1_responder_if;
    import mbc_pkg::*;

    logic [MEM_AW-1:0] mem_a;
    logic [1:0]        mem_space;
    logic              mem_req;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_a, mem_space, mem_req, mem_we, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_a, mem_space, mem_req, mem_we, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mbc1_regs.sv
// rtl/mbc1_regs.sv - MBC1 enable/bank/mode registers and banked ROM / cart RAM addresses
module mbc1_regs
    import mbc_pkg::*;
#(
    parameter int ROM_BANK_BITS = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [14:0]       a,
    input  logic [4:0]        din,
    output logic              ram_en,
    output logic [MEM_AW-1:0] rom_addr,
    output logic [MEM_AW-1:0] cram_addr
);
    localparam logic [6:0] BANK_MASK = 7'((1 << ROM_BANK_BITS) - 1);

    logic [4:0] bank_lo;
    logic [1:0] bank_hi;
    logic       mode;
    logic [6:0] bank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_en  <= 1'b0;
            bank_lo <= 5'd1;
            bank_hi <= 2'd0;
            mode    <= 1'b0;
        end else if (we) begin
            case (a[14:13])
                2'd0: ram_en  <= (din[3:0] == 4'hA);
                2'd1: bank_lo <= (din == 5'd0) ? 5'd1 : din;
                2'd2: bank_hi <= din[1:0];
                default: mode <= din[0];
            endcase
        end
    end

    // Lower ROM window only sees bank_hi in mode 1; the upper window always sees the full bank.
    always_comb begin
        if (a[14])
            bank = {bank_hi, bank_lo};
        else
            bank = mode ? {bank_hi, 5'b0} : 7'd0;
    end

    assign rom_addr  = {bank & BANK_MASK, a[13:0]};
    assign cram_addr = {6'b0, (mode ? bank_hi : 2'b0), a[12:0]};

endmodule

// File: rtl/mbc1_responder.sv
// rtl/mbc1_responder.sv - MBC1 cartridge responder: bus decode and backing-store request FSM
module mbc1_responder
    import mbc_pkg::*;
#(
    parameter int ROM_BANK_BITS = 7,
    parameter bit CRAM_PRESENT  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ct,
    input  logic [15:0]      a,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    input  logic             rd,
    input  logic             wr,
    mbc1_responder_if.master mem,
    output logic             late
);
    region_t           region;
    state_t            state;
    logic              overdue;
    logic              ram_en;
    logic              cram_on;
    logic              reg_we;
    logic              launch;
    logic              ff_read;
    logic [MEM_AW-1:0] rom_addr;
    logic [MEM_AW-1:0] cram_addr;
    logic [MEM_AW-1:0] tgt_addr;
    logic [1:0]        tgt_space;

    assign reg_we  = wr && (ct == 2'd3) && (a <= ROM_END);
    assign cram_on = CRAM_PRESENT && ram_en;

    mbc1_regs #(
        .ROM_BANK_BITS(ROM_BANK_BITS)
    ) u_regs (
        .clk       (clk),
        .rst       (rst),
        .we        (reg_we),
        .a         (a[14:0]),
        .din       (din[4:0]),
        .ram_en    (ram_en),
        .rom_addr  (rom_addr),
        .cram_addr (cram_addr)
    );

    always_comb begin
        region = REGION_UNMAPPED;
        if (a <= ROM_END)
            region = REGION_ROM;
        else if (a >= CRAM_BASE && a <= CRAM_END)
            region = REGION_CRAM;
        else if (a >= WRAM_BASE && a <= ECHO_END)
            region = REGION_WRAM;
    end

    // A write into ROM space is a register write, never a backing-store access.
    always_comb begin
        launch    = 1'b0;
        ff_read   = 1'b0;
        tgt_addr  = '0;
        tgt_space = SPACE_ROM;
        if (ct == 2'd0 && (rd || wr)) begin
            case (region)
                REGION_ROM: begin
                    launch    = !wr;
                    tgt_addr  = rom_addr;
                    tgt_space = SPACE_ROM;
                end
                REGION_CRAM: begin
                    launch    = cram_on;
                    ff_read   = !cram_on && !wr;
                    tgt_addr  = cram_addr;
                    tgt_space = SPACE_CRAM;
                end
                REGION_WRAM: begin
                    launch    = 1'b1;
                    tgt_addr  = {{(MEM_AW-13){1'b0}}, a[12:0]};
                    tgt_space = SPACE_WRAM;
                end
                default: ff_read = !wr;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            overdue       <= 1'b0;
            late          <= 1'b0;
            dout          <= 8'hFF;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_a     <= '0;
            mem.mem_space <= SPACE_ROM;
            mem.mem_wdata <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        state         <= ST_REQ;
                        overdue       <= 1'b0;
                        mem.mem_req   <= 1'b1;
                        mem.mem_a     <= tgt_addr;
                        mem.mem_space <= tgt_space;
                        mem.mem_we    <= wr;
                        mem.mem_wdata <= din;
                    end
                end
                ST_REQ: begin
                    if (launch)
                        late <= 1'b1;
                    // overdue marks that the ct=3 edge of the launch cycle passed without an ack.
                    if (mem.mem_ack) begin
                        state       <= ST_IDLE;
                        mem.mem_req <= 1'b0;
                        if (!mem.mem_we)
                            dout <= mem.mem_rdata;
                        if (overdue)
                            late <= 1'b1;
                    end else if (ct == 2'd3) begin
                        overdue <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (ff_read)
                dout <= 8'hFF;
        end
    end

endmodule
